// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 3-port register file: pipeline writeback wins, multiply/divide results queue in a FIFO.
// Optional macro REGFILE_ARB_BYPASS_EN sends a multiply/divide result straight to the write port when nothing is queued.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,
    input  logic          md_valid,
    input  logic [AW-1:0] md_wa,
    input  logic [DW-1:0] md_wd,
    output logic          md_ready,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          pend1,
    output logic          pend2
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_wa_q [DEPTH];
    logic [DW-1:0] mem_wd_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          we3_q, we3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d;

    logic wb_act, md_acc, push, pop, byp;

    always_comb begin
        wb_act   = wb_we && (wb_wa != '0);
        md_ready = reset_n && (count_q != CW'(DEPTH));
        md_acc   = md_valid && md_ready;
        pop      = !wb_act && (count_q != '0);
`ifdef REGFILE_ARB_BYPASS_EN
        byp      = md_acc && (md_wa != '0) && (count_q == '0) && !wb_act;
`else
        byp      = 1'b0;
`endif
        push     = md_acc && (md_wa != '0) && !byp;

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (wb_act) begin
            we3_d = 1'b1;
            wa3_d = wb_wa;
            wd3_d = wb_wd;
        end else if (pop) begin
            we3_d = 1'b1;
            wa3_d = mem_wa_q[rd_ptr_q];
            wd3_d = mem_wd_q[rd_ptr_q];
        end else if (byp) begin
            we3_d = 1'b1;
            wa3_d = md_wa;
            wd3_d = md_wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    // Storage needs no reset: entries are qualified by their distance from the read pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_wa_q[wr_ptr_q] <= md_wa;
            mem_wd_q[wr_ptr_q] <= md_wd;
        end
    end

    logic [PW-1:0] off;
    logic          hit1, hit2;

    always_comb begin
        off  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) begin
                if (mem_wa_q[i] == ra1) hit1 = 1'b1;
                if (mem_wa_q[i] == ra2) hit2 = 1'b1;
            end
        end
        // The output stage counts as pending until the register file commits it.
        pend1 = (ra1 != '0) && (hit1 || (we3_q && (wa3_q == ra1)));
        pend2 = (ra2 != '0) && (hit2 || (we3_q && (wa3_q == ra2)));
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (DEPTH=4, AW=5, DW=32).
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        md_valid;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic        md_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        pend1;
    logic        pend2;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_we    (wb_we),
        .wb_wa    (wb_wa),
        .wb_wd    (wb_wd),
        .md_valid (md_valid),
        .md_wa    (md_wa),
        .md_wd    (md_wd),
        .md_ready (md_ready),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .ra1      (ra1),
        .ra2      (ra2),
        .pend1    (pend1),
        .pend2    (pend2)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        wb_we    = 1'b0;
        wb_wa    = '0;
        wb_wd    = '0;
        md_valid = 1'b0;
        md_wa    = '0;
        md_wd    = '0;
        ra1      = '0;
        ra2      = '0;

        // Reset, then reset again with two buffered entries
        step;
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_md_ready", 32'(md_ready), 32'd0);
        chk("rst_count", 32'(dut.count_q), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_md_ready", 32'(md_ready), 32'd1);
        wb_we = 1'b1; wb_wa = 5'd10; wb_wd = 32'hAAAA;
        md_valid = 1'b1; md_wa = 5'd1; md_wd = 32'h11;
        step;
        md_wa = 5'd2; md_wd = 32'h22;
        step;
        chk("buf2_count", 32'(dut.count_q), 32'd2);
        chk("buf2_wa3", 32'(wa3), 32'd10);
        wb_we = 1'b0; md_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_we3", 32'(we3), 32'd0);
        chk("midrst_md_ready", 32'(md_ready), 32'd0);
        chk("midrst_count", 32'(dut.count_q), 32'd0);
        step;
        chk("midrst_edge_we3", 32'(we3), 32'd0);
        reset_n = 1'b1;
        step;
        chk("after_rel_md_ready", 32'(md_ready), 32'd1);
        chk("after_rel_count", 32'(dut.count_q), 32'd0);
        chk("after_rel_no_drain", 32'(we3), 32'd0);
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h1234;
        step;
        chk("wb_we3", 32'(we3), 32'd1);
        chk("wb_wa3", 32'(wa3), 32'd5);
        chk("wb_wd3", wd3, 32'h1234);
        wb_we = 1'b0;
        step;
        chk("idle_we3", 32'(we3), 32'd0);
        chk("idle_wa3_hold", 32'(wa3), 32'd5);
        chk("idle_wd3_hold", wd3, 32'h1234);

        // x0 filtering
        wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hFFFF;
        step;
        chk("x0wb_we3", 32'(we3), 32'd0);
        chk("x0wb_wa3", 32'(wa3), 32'd5);
        wb_we = 1'b0;
        md_valid = 1'b1; md_wa = 5'd0; md_wd = 32'h77;
        #1;
        chk("x0md_ready_pre", 32'(md_ready), 32'd1);
        step;
        md_valid = 1'b0;
        #1;
        chk("x0md_count", 32'(dut.count_q), 32'd0);
        chk("x0md_we3", 32'(we3), 32'd0);
        chk("x0md_ready", 32'(md_ready), 32'd1);

        // Fill under continuous pipeline writes, then drain in order
        wb_we = 1'b1;
        md_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wb_wa = 5'(20 + k); wb_wd = 32'(k);
            md_wa = 5'(k); md_wd = 32'(32'h100 + k);
            step;
            chk("fill_wa3", 32'(wa3), 32'(20 + k));
        end
        chk("full_md_ready", 32'(md_ready), 32'd0);
        chk("full_count", 32'(dut.count_q), 32'd4);
        md_wa = 5'd5; md_wd = 32'h105;
        wb_wa = 5'd25;
        for (int k = 0; k < 2; k++) begin
            step;
            chk("hold_count", 32'(dut.count_q), 32'd4);
            chk("hold_md_ready", 32'(md_ready), 32'd0);
            chk("hold_wa3", 32'(wa3), 32'd25);
        end
        wb_we = 1'b0;
        step;
        chk("drain1_we3", 32'(we3), 32'd1);
        chk("drain1_wa3", 32'(wa3), 32'd1);
        chk("drain1_wd3", wd3, 32'h101);
        chk("drain1_count", 32'(dut.count_q), 32'd3);
        chk("drain1_md_ready", 32'(md_ready), 32'd1);
        step;
        md_valid = 1'b0;
        chk("drain2_wa3", 32'(wa3), 32'd2);
        chk("drain2_wd3", wd3, 32'h102);
        chk("drain2_count", 32'(dut.count_q), 32'd3);
        step;
        chk("drain3_wa3", 32'(wa3), 32'd3);
        chk("drain3_wd3", wd3, 32'h103);
        step;
        chk("drain4_wa3", 32'(wa3), 32'd4);
        chk("drain4_wd3", wd3, 32'h104);
        step;
        chk("drain5_we3", 32'(we3), 32'd1);
        chk("drain5_wa3", 32'(wa3), 32'd5);
        chk("drain5_wd3", wd3, 32'h105);
        chk("drain5_count", 32'(dut.count_q), 32'd0);
        step;
        chk("drained_we3", 32'(we3), 32'd0);

        // Simultaneous push and pop
        wb_we = 1'b1; wb_wa = 5'd26; wb_wd = 32'h26;
        md_valid = 1'b1; md_wa = 5'd11; md_wd = 32'h111;
        step;
        md_wa = 5'd12; md_wd = 32'h112;
        step;
        chk("pp_pre_count", 32'(dut.count_q), 32'd2);
        wb_we = 1'b0;
        md_wa = 5'd7; md_wd = 32'h107;
        step;
        md_valid = 1'b0;
        chk("pp_count", 32'(dut.count_q), 32'd2);
        chk("pp_we3", 32'(we3), 32'd1);
        chk("pp_wa3", 32'(wa3), 32'd11);
        chk("pp_wd3", wd3, 32'h111);
        step;
        chk("pp_d2_wa3", 32'(wa3), 32'd12);
        chk("pp_d2_count", 32'(dut.count_q), 32'd1);
        step;
        chk("pp_d3_wa3", 32'(wa3), 32'd7);
        chk("pp_d3_wd3", wd3, 32'h107);
        chk("pp_d3_count", 32'(dut.count_q), 32'd0);
        step;
        chk("pp_idle_we3", 32'(we3), 32'd0);

        // Pending hazards
        wb_we = 1'b1; wb_wa = 5'd27; wb_wd = 32'h27;
        md_valid = 1'b1; md_wa = 5'd9; md_wd = 32'h99;
        step;
        md_valid = 1'b0;
        ra1 = 5'd9; ra2 = 5'd0;
        #1;
        chk("pend_buf_pend1", 32'(pend1), 32'd1);
        chk("pend_buf_pend2", 32'(pend2), 32'd0);
        chk("pend_buf_count", 32'(dut.count_q), 32'd1);
        step;
        chk("pend_blk_pend1", 32'(pend1), 32'd1);
        chk("pend_blk_wa3", 32'(wa3), 32'd27);
        ra2 = 5'd27;
        #1;
        chk("pend_out_pend2", 32'(pend2), 32'd1);
        ra2 = 5'd0;
        wb_we = 1'b0;
        step;
        chk("pend_wr_we3", 32'(we3), 32'd1);
        chk("pend_wr_wa3", 32'(wa3), 32'd9);
        chk("pend_wr_wd3", wd3, 32'h99);
        chk("pend_wr_count", 32'(dut.count_q), 32'd0);
        chk("pend_wr_pend1", 32'(pend1), 32'd1);
        step;
        chk("pend_done_we3", 32'(we3), 32'd0);
        chk("pend_done_pend1", 32'(pend1), 32'd0);
        ra1 = 5'd0;

        // Bypass versus FIFO latency
        md_valid = 1'b1; md_wa = 5'd3; md_wd = 32'hBEEF;
        step;
        md_valid = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
        chk("byp_we3", 32'(we3), 32'd1);
        chk("byp_wa3", 32'(wa3), 32'd3);
        chk("byp_wd3", wd3, 32'hBEEF);
        chk("byp_count", 32'(dut.count_q), 32'd0);
        step;
        chk("byp_after_we3", 32'(we3), 32'd0);
`else
        chk("nobyp_e1_we3", 32'(we3), 32'd0);
        chk("nobyp_e1_count", 32'(dut.count_q), 32'd1);
        step;
        chk("nobyp_we3", 32'(we3), 32'd1);
        chk("nobyp_wa3", 32'(wa3), 32'd3);
        chk("nobyp_wd3", wd3, 32'hBEEF);
        chk("nobyp_count", 32'(dut.count_q), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
